icache_readonly: RTL and testbench
==================================

Name: icache_readonly

Overview:
- Direct-mapped, read-only instruction cache between the pipeline's ICACHE_* port and the slow instruction memory.
- Serves word reads in the same cycle on a hit.
- On a miss, stalls the pipeline while a 4-word line is fetched from memory through a ready-handshaked 128-bit port.
- Consumes exactly the ICACHE_ren/ICACHE_addr/ICACHE_stall/ICACHE_rdata signals the IF stage produces.

Parameters:
- INDEX_W, 3, index bits; number of lines = 2**INDEX_W (default 8).
- ADDR_W, 30, processor word-address width.
- TAG_W, ADDR_W-INDEX_W-2, tag width (default 25); derived, not to be overridden.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- proc_read  in  1  pipeline read request (ICACHE_ren).
- proc_write  in  1  pipeline write request (ICACHE_wen); ignored.
- proc_addr  in  30  word address; [1:0] word offset, [INDEX_W+1:2] index, upper bits tag.
- proc_wdata  in  32  unused.
- proc_rdata  out  32  selected word of the indexed line.
- proc_stall  out  1  high while the request cannot be served this cycle.
- mem_read  out  1  memory line-read request, registered.
- mem_write  out  1  tied 0.
- mem_addr  out  28  line address = proc_addr[29:2], registered.
- mem_wdata  out  128  tied 0.
- mem_rdata  in  128  line data; word k in bits [32k+31:32k].
- mem_ready  in  1  one-cycle pulse; mem_rdata valid that cycle.

Behaviour:
- Storage: per line a valid bit, TAG_W tag and 128-bit data. Valid bits live in flops; all other state may be plain registers.
- hit = valid[index] && tag[index]==addr tag.
- Reset (any state, including mid-FETCH):
  - all valid bits cleared; state to IDLE.
  - mem_read=0, mem_addr=0 on the next edge.
  - proc_stall forced 0 while rst is high.
  - A memory response arriving after reset is ignored.
- proc_rdata is combinational from the indexed line and offset, regardless of hit.
  - Value is don't-care when proc_stall=1 or proc_read=0.
  - After reset, reads as 0 (data cleared) until a fill occurs.
- State IDLE:
  - proc_stall = proc_read && !hit (combinational).
  - On proc_read && !hit: register mem_addr=proc_addr[29:2], set mem_read=1, go to FETCH.
  - Otherwise stay.
  - mem_ready in IDLE is ignored.
- State FETCH:
  - proc_stall=1 unconditionally. mem_read held 1; mem_addr held constant.
  - On mem_ready: write mem_rdata into line mem_addr[INDEX_W-1:0], set tag=mem_addr[27:INDEX_W] and valid=1, drop mem_read, go to IDLE.
  - The fill completes even if proc_read drops or proc_addr changes during FETCH. The refilled line stays valid.
  - In IDLE the next cycle, the current request is re-evaluated (hit serves, new miss starts a new FETCH).
- Miss timing:
  - Miss detected cycle 0; mem_read visible from cycle 1.
  - If mem_ready arrives in cycle N, proc_stall is low in cycle N+1 with correct proc_rdata.
  - A back-to-back miss in cycle N+1 re-asserts mem_read in N+2; mem_read is low for at least one cycle between requests.
- Replacement: direct-mapped, unconditional overwrite. No write-back; the cache is never dirty.
- proc_write=1 never stalls and never modifies state. If proc_read and proc_write are both asserted, only the read is served.

Test Plan:
1. Cold miss: rst then proc_read=1, addr=0x00000011, memory responds 3 cycles after mem_read with line {0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000} -> mem_addr=0x0000004, stall 5 cycles total, then proc_rdata=0xBBBB0001, stall 0.
2. Hit after fill: addr 0x00000010, 0x12, 0x13 on consecutive cycles -> no stall, rdata 0xAAAA0000, 0xCCCC0002, 0xDDDD0003, mem_read stays 0.
3. Conflict eviction: fill addr 0x00 (index 0, tag 0), then read 0x20 (index 0, tag 1) -> miss, mem_addr=0x0000008, line replaced; re-read 0x00 -> miss again with mem_addr=0x0000000.
4. Request withdrawn mid-FETCH: miss on 0x40, drop proc_read in cycle 2, mem_ready in cycle 4 -> line filled; later read of 0x40 hits with zero stall.
5. Reset mid-FETCH: assert rst one cycle during FETCH, late mem_ready after reset -> mem_read 0 after the edge, no line valid, next read of the same address misses.
6. Write ignored: proc_write=1, proc_read=0, addr=0x10 after fill -> proc_stall=0, no mem traffic, subsequent read of 0x10 returns original 0xAAAA0000.

Source files
------------

// File: rtl/icache_readonly_if.sv
// Bus bundle between the IF stage, the instruction cache and the instruction memory.
// The slave modport is the cache view; the master modport is the pipeline/memory side.
interface icache_readonly_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/icache_readonly.sv
// Direct-mapped read-only instruction cache with 4-word lines.
// A miss stalls the pipeline while a full line is fetched over the 128-bit memory port.
module icache_readonly #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned ADDR_W  = 30
) (
    input  logic               clk,
    input  logic               rst,
    icache_readonly_if.slave   bus
);
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
    localparam int unsigned LINES = 2 ** INDEX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [3:0][31:0]       data_q [LINES];
    logic                   mem_read_q;
    logic [ADDR_W-3:0]      mem_addr_q;

    logic [INDEX_W-1:0]     index;
    logic [TAG_W-1:0]       req_tag;
    logic [1:0]             offset;
    logic [INDEX_W-1:0]     fill_idx;
    logic                   hit;
    logic                   stall_c;
    logic                   start_c;
    logic                   fill_c;

    // Write path is not supported; these inputs are intentionally dropped.
    logic unused_inputs;
    assign unused_inputs = ^{bus.proc_write, bus.proc_wdata};

    assign offset   = bus.proc_addr[1:0];
    assign index    = bus.proc_addr[INDEX_W+1:2];
    assign req_tag  = bus.proc_addr[ADDR_W-1:INDEX_W+2];
    assign fill_idx = mem_addr_q[INDEX_W-1:0];
    assign hit      = valid_q[index] && (tag_q[index] == req_tag);

    assign bus.proc_rdata = data_q[index][offset];
    assign bus.proc_stall = stall_c;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_write  = 1'b0;
    assign bus.mem_wdata  = 128'(0);

    // Next state and combinational stall/fill controls.
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        start_c = 1'b0;
        fill_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.proc_read && !hit) begin
                    stall_c = 1'b1;
                    start_c = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                stall_c = 1'b1;
                if (bus.mem_ready) begin
                    fill_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            stall_c = 1'b0;
        end
    end

    // State, memory request and line storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            for (int i = 0; i < int'(LINES); i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (start_c) begin
                mem_read_q <= 1'b1;
                mem_addr_q <= bus.proc_addr[ADDR_W-1:2];
            end
            if (fill_c) begin
                mem_read_q        <= 1'b0;
                data_q[fill_idx]  <= bus.mem_rdata;
                tag_q[fill_idx]   <= mem_addr_q[ADDR_W-3:INDEX_W];
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_icache_readonly.sv
// Directed testbench for icache_readonly: cold miss, hits, eviction,
// withdrawn request, reset during fetch and ignored writes.
module tb_icache_readonly;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    icache_readonly_if bus ();

    icache_readonly dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [127:0] LINE1 = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    localparam logic [127:0] LINEA = 128'h0A000003_0A000002_0A000001_0A000000;
    localparam logic [127:0] LINEB = 128'h0B000003_0B000002_0B000001_0B000000;
    localparam logic [127:0] LINEC = 128'h0C000003_0C000002_0C000001_0C000000;
    localparam logic [127:0] LINED = 128'h0D000003_0D000002_0D000001_0D000000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a read at addr and act as memory, replying lat cycles after mem_read rises.
    // Returns at the negedge of the first unstalled cycle with proc_read still high.
    task automatic serve_miss(input logic [29:0] addr, input logic [127:0] line, input int lat,
                              output int stalls, output logic [27:0] maddr, output logic ok);
        int since;
        since  = -1;
        stalls = 0;
        ok     = 1'b0;
        maddr  = '0;
        bus.proc_read = 1'b1;
        bus.proc_addr = addr;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus.proc_stall) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            if (bus.mem_read) begin
                since++;
                maddr = bus.mem_addr;
                if (since == lat) begin
                    bus.mem_rdata = line;
                    bus.mem_ready = 1'b1;
                end
            end
            tick();
            bus.mem_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h11;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (bus.proc_stall !== 1'b0) begin
                bad++; $display("FAIL reset_stall got=%b want=0", bus.proc_stall);
            end
            total++;
            if (bus.mem_read !== 1'b0 || bus.mem_addr !== 28'h0) begin
                bad++; $display("FAIL reset_mem got=%b/%h want=0/0000000", bus.mem_read, bus.mem_addr);
            end
            total++;
            if (bus.proc_rdata !== 32'h0) begin
                bad++; $display("FAIL reset_rdata got=%h want=00000000", bus.proc_rdata);
            end
        end
        tick();
        rst = 1'b0;
        bus.proc_read = 1'b0;
    endtask

    task automatic test_cold_miss();
        int stalls; logic [27:0] maddr; logic ok;
        tick();
        serve_miss(30'h11, LINE1, 3, stalls, maddr, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL cold_timeout got=stalled want=served"); end
        total++;
        if (stalls !== 5) begin bad++; $display("FAIL cold_stalls got=%0d want=5", stalls); end
        total++;
        if (maddr !== 28'h4) begin bad++; $display("FAIL cold_maddr got=%h want=0000004", maddr); end
        total++;
        if (bus.proc_rdata !== 32'hBBBB0001) begin
            bad++; $display("FAIL cold_rdata got=%h want=bbbb0001", bus.proc_rdata);
        end
        total++;
        if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL cold_memread got=%b want=0", bus.mem_read); end
    endtask

    task automatic test_hits();
        logic [29:0] addrs [3];
        logic [31:0] exp   [3];
        addrs = '{30'h10, 30'h12, 30'h13};
        exp   = '{32'hAAAA0000, 32'hCCCC0002, 32'hDDDD0003};
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.proc_read = 1'b1;
            bus.proc_addr = addrs[i];
            @(negedge clk);
            total++;
            if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0) begin
                bad++; $display("FAIL hit_stall[%0d] got=%b/%b want=0/0", i, bus.proc_stall, bus.mem_read);
            end
            total++;
            if (bus.proc_rdata !== exp[i]) begin
                bad++; $display("FAIL hit_rdata[%0d] got=%h want=%h", i, bus.proc_rdata, exp[i]);
            end
        end
    endtask

    task automatic test_conflict();
        int stalls; logic [27:0] maddr; logic ok;
        tick();
        serve_miss(30'h00, LINEA, 1, stalls, maddr, ok);
        total++;
        if (!ok || maddr !== 28'h0 || bus.proc_rdata !== 32'h0A000000) begin
            bad++; $display("FAIL fill0 got=%b/%h/%h want=1/0000000/0a000000", ok, maddr, bus.proc_rdata);
        end
        tick();
        serve_miss(30'h20, LINEB, 2, stalls, maddr, ok);
        total++;
        if (!ok || stalls !== 4) begin bad++; $display("FAIL evict_stalls got=%b/%0d want=1/4", ok, stalls); end
        total++;
        if (maddr !== 28'h8) begin bad++; $display("FAIL evict_maddr got=%h want=0000008", maddr); end
        total++;
        if (bus.proc_rdata !== 32'h0B000000) begin
            bad++; $display("FAIL evict_rdata got=%h want=0b000000", bus.proc_rdata);
        end
        total++;
        if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL evict_gap got=%b want=0", bus.mem_read); end
        tick();
        serve_miss(30'h00, LINEA, 0, stalls, maddr, ok);
        total++;
        if (!ok || stalls !== 2 || maddr !== 28'h0) begin
            bad++; $display("FAIL remiss got=%b/%0d/%h want=1/2/0000000", ok, stalls, maddr);
        end
        total++;
        if (bus.proc_rdata !== 32'h0A000000) begin
            bad++; $display("FAIL remiss_rdata got=%h want=0a000000", bus.proc_rdata);
        end
    endtask

    task automatic test_withdrawn();
        tick();
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h40;
        @(negedge clk);
        total++;
        if (bus.proc_stall !== 1'b1) begin bad++; $display("FAIL wd_c0_stall got=%b want=1", bus.proc_stall); end
        tick();
        @(negedge clk);
        total++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h10) begin
            bad++; $display("FAIL wd_c1_mem got=%b/%h want=1/0000010", bus.mem_read, bus.mem_addr);
        end
        tick();
        bus.proc_read = 1'b0;
        bus.proc_addr = 30'h3F;
        @(negedge clk);
        total++;
        if (bus.proc_stall !== 1'b1 || bus.mem_addr !== 28'h10) begin
            bad++; $display("FAIL wd_c2 got=%b/%h want=1/0000010", bus.proc_stall, bus.mem_addr);
        end
        tick();
        tick();
        bus.mem_rdata = LINEC;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mem_read !== 1'b0 || bus.proc_stall !== 1'b0) begin
            bad++; $display("FAIL wd_c5 got=%b/%b want=0/0", bus.mem_read, bus.proc_stall);
        end
        tick();
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h42;
        @(negedge clk);
        total++;
        if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h0C000002) begin
            bad++; $display("FAIL wd_hit got=%b/%h want=0/0c000002", bus.proc_stall, bus.proc_rdata);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int stalls; logic [27:0] maddr; logic ok;
        tick();
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h60;
        tick();
        @(negedge clk);
        total++;
        if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL rmf_fetch got=%b want=1", bus.mem_read); end
        tick();
        rst = 1'b1;
        bus.proc_read = 1'b0;
        @(negedge clk);
        total++;
        if (bus.proc_stall !== 1'b0) begin bad++; $display("FAIL rmf_stall got=%b want=0", bus.proc_stall); end
        tick();
        rst = 1'b0;
        bus.mem_rdata = LINED;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.mem_read !== 1'b0 || bus.mem_addr !== 28'h0) begin
            bad++; $display("FAIL rmf_mem got=%b/%h want=0/0000000", bus.mem_read, bus.mem_addr);
        end
        total++;
        if (bus.proc_rdata !== 32'h0) begin bad++; $display("FAIL rmf_rdata got=%h want=00000000", bus.proc_rdata); end
        tick();
        bus.mem_ready = 1'b0;
        serve_miss(30'h10, LINE1, 0, stalls, maddr, ok);
        total++;
        if (!ok || stalls !== 2 || maddr !== 28'h4) begin
            bad++; $display("FAIL rmf_miss10 got=%b/%0d/%h want=1/2/0000004", ok, stalls, maddr);
        end
        tick();
        serve_miss(30'h60, LINED, 0, stalls, maddr, ok);
        total++;
        if (!ok || stalls !== 2 || maddr !== 28'h18 || bus.proc_rdata !== 32'h0D000000) begin
            bad++; $display("FAIL rmf_miss60 got=%b/%0d/%h/%h want=1/2/0000018/0d000000",
                            ok, stalls, maddr, bus.proc_rdata);
        end
    endtask

    task automatic test_write_ignored();
        tick();
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b1;
        bus.proc_addr  = 30'h10;
        bus.proc_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0) begin
                bad++; $display("FAIL wr_quiet[%0d] got=%b/%b want=0/0", i, bus.proc_stall, bus.mem_read);
            end
            tick();
        end
        bus.proc_write = 1'b0;
        bus.proc_read  = 1'b1;
        @(negedge clk);
        total++;
        if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'hAAAA0000) begin
            bad++; $display("FAIL wr_readback got=%b/%h want=0/aaaa0000", bus.proc_stall, bus.proc_rdata);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        test_reset();
        test_cold_miss();
        test_hits();
        test_conflict();
        test_withdrawn();
        test_reset_mid_fetch();
        test_write_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
